move_stack: RTL and testbench
=============================

# move_stack

Direction store for the maze-solving rat datapath, directly downstream of the rat controller. It records each accepted move while the maze is explored and hands back the most recent move when the controller backtracks. Once the exit is reached, it replays the surviving path oldest-first as a stream of moves for display. It consumes the controller's `push`/`pop`/`qpop`/`show` strobes and returns `poped` and `err`.

## Interface
- `DEPTH`, 256, maximum stored path length in moves (power of two)
- `AW`, `$clog2(DEPTH)`, pointer width
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-high reset
- `clr` in 1: synchronous clear; empties the store and clears flags (tied to controller start)
- `push` in 1: store `din` on top (solve mode)
- `pop` in 1: remove top entry (solve mode)
- `din` in 2: direction to push (UP=0, RIGHT=1, LEFT=2, DOWN=3)
- `poped` out 2: direction removed by the most recent accepted pop
- `show` in 1: replay mode select
- `qpop` in 1: request next replay move (valid only while `show`=1)
- `move_out` out 2: replayed direction
- `move_valid` out 1: one-cycle strobe qualifying `move_out`
- `err` out 1: replay exhausted
- `empty` out 1: stack holds no entries
- `full` out 1: stack holds `DEPTH` entries
- `no_path` out 1: sticky; a pop was issued while empty
- `ovf` out 1: sticky; a push was issued while full
- `count` out AW+1: current depth

## Operation
- State: top pointer `sp` (0..DEPTH), replay pointer `rp` (0..DEPTH), storage array of 2-bit entries.
- **Solve mode (`show`=0):**
  - Push when not full: `mem[sp]<=din`, `sp<=sp+1`.
  - Pop when not empty: `poped<=mem[sp-1]`, `sp<=sp-1`.
  - `poped` holds its value until the next accepted pop.
  - Push and pop in the same cycle perform a replace: `poped<=mem[sp-1]`, `mem[sp-1]<=din`, `sp` unchanged. If the stack is empty, this is a plain push and sets `no_path`.
  - Push while full is dropped and sets `ovf`.
  - Pop while empty is dropped, sets `no_path`, and leaves `poped` unchanged.
  - `rp` is held at 0.
- **Replay mode (`show`=1):**
  - `push`/`pop` are ignored and `sp` is frozen.
  - `qpop` with `rp<sp`: `move_out<=mem[rp]`, `move_valid<=1`, `rp<=rp+1`.
  - `qpop` with `rp==sp`: `err<=1`, `move_valid<=0`.
  - `err` stays high while `qpop` and `show` remain high, and clears the cycle after either drops.
  - A fall of `show` resets `rp` to 0, so a later replay restarts from the oldest move.
- `qpop` while `show`=0 is ignored.
- `clr` (and `rst`) set `sp`, `rp`, `poped`, `move_out`, `move_valid`, `err`, `no_path`, `ovf` to 0. Memory contents are not cleared.
- Flags: `empty`=(`sp`==0), `full`=(`sp`==DEPTH), `count`=`sp`. All are combinational from registered `sp`.

## Timing
- Reset values: all outputs 0 except `empty`=1.
- Push: the entry is visible in `count` the next cycle.
- Pop: `poped` is valid on the first edge after the pop cycle. The controller samples it three cycles later, which meets this with margin.
- Replay latency: `qpop` in cycle N gives `move_out`/`move_valid` in cycle N+1. Back-to-back `qpop` gives one move per cycle.
- `err` is registered and appears in cycle N+1 after the exhausting `qpop`.
- `rst` mid-replay or mid-solve aborts immediately and asynchronously. `clr` takes effect at the next edge and overrides `push`/`pop`/`qpop` in the same cycle.

## Configuration
- `MOVE_STACK_STATS_EN` defined:
  - Adds output `max_depth` (AW+1), the high-water mark of `sp` since the last `rst`/`clr`.
  - Adds output `replayed` (AW+1), the number of moves emitted in the current replay.
- Undefined: neither port exists and no extra registers are built.

## Structure
- Shared package holds:
  - direction constants UP/RIGHT/LEFT/DOWN
  - `DIR_W`=2
  - the `dir_t` typedef, reused by the controller and display blocks
- Sub-module `path_ram`: DEPTH×2 array with one synchronous write port and one synchronous read port.
  - Read address mux: `sp-1` in solve mode, `rp` in replay mode.
  - Replace reads the old data on the same edge as the write (read-before-write).

## Test plan
- Push UP, RIGHT, RIGHT, DOWN; pop → `poped`=DOWN, `count`=3; pop → `poped`=RIGHT, `count`=2.
- Push UP, LEFT; set `show`=1; hold `qpop` 3 cycles → `move_out` UP then LEFT with `move_valid` high 2 cycles, then `err`=1; drop `qpop` → `err`=0 next cycle.
- From empty, pop → `no_path`=1, `poped` unchanged; push DEPTH+1 times → `full`=1, `ovf`=1, `count`=DEPTH.
- Push 3 entries, assert `push`(din=LEFT)+`pop` together → `count`=3, `poped`=old top; replay ends with LEFT.
- Push 2 entries, assert `push` with `show`=1 → `count`=2; assert `rst` mid-replay → all outputs 0, `empty`=1.
- With `MOVE_STACK_STATS_EN`: push 5, pop 3 → `max_depth`=5, `count`=2; replay 2 moves → `replayed`=2.

Source files
------------

// File: rtl/move_stack_pkg.sv
// Shared direction encoding for the rat datapath (controller, move stack, display).
package move_stack_pkg;

    localparam int unsigned DIR_W = 2;

    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t UP    = 2'd0;
    localparam dir_t RIGHT = 2'd1;
    localparam dir_t LEFT  = 2'd2;
    localparam dir_t DOWN  = 2'd3;

endpackage

// File: rtl/move_stack_path_ram.sv
// DEPTH x DIR_W path storage: one synchronous write port, one synchronous read port
// whose data lands in either the pop register or the replay register.
module path_ram
    import move_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [DIR_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    input  logic             rd_pop,
    input  logic             rd_rep,
    output logic [DIR_W-1:0] pop_data,
    output logic [DIR_W-1:0] rep_data
);

    logic [DIR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Non-blocking read of the old word gives read-before-write on a replace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_data <= '0;
            rep_data <= '0;
        end else if (clr) begin
            pop_data <= '0;
            rep_data <= '0;
        end else begin
            if (rd_pop) pop_data <= mem[raddr];
            if (rd_rep) rep_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/move_stack.sv
// Move stack: records accepted moves, returns the top on backtrack, replays oldest-first.
// Optional MOVE_STACK_STATS_EN adds max_depth and replayed outputs.
module move_stack
    import move_stack_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [DIR_W-1:0] din,
    output logic [DIR_W-1:0] poped,
    input  logic             show,
    input  logic             qpop,
    output logic [DIR_W-1:0] move_out,
    output logic             move_valid,
    output logic             err,
    output logic             empty,
    output logic             full,
    output logic             no_path,
    output logic             ovf,
`ifdef MOVE_STACK_STATS_EN
    output logic [AW:0]      max_depth,
    output logic [AW:0]      replayed,
`endif
    output logic [AW:0]      count
);

    logic [AW:0]   sp, sp_next, rp, rp_next;
    logic          mv_next, err_next, no_path_next, ovf_next;
    logic          we, rd_pop, rd_rep;
    logic [AW-1:0] waddr, raddr;

    assign empty = (sp == '0);
    assign full  = (sp == (AW+1)'(DEPTH));
    assign count = sp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp         <= '0;
            rp         <= '0;
            move_valid <= 1'b0;
            err        <= 1'b0;
            no_path    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            sp         <= sp_next;
            rp         <= rp_next;
            move_valid <= mv_next;
            err        <= err_next;
            no_path    <= no_path_next;
            ovf        <= ovf_next;
        end
    end

    // Solve/replay decode; clr overrides every strobe in the same cycle.
    always_comb begin
        sp_next      = sp;
        rp_next      = rp;
        mv_next      = 1'b0;
        err_next     = 1'b0;
        no_path_next = no_path;
        ovf_next     = ovf;
        we           = 1'b0;
        rd_pop       = 1'b0;
        rd_rep       = 1'b0;
        waddr        = AW'(sp);
        raddr        = show ? AW'(rp) : AW'(sp - (AW+1)'(1));

        if (!show) begin
            rp_next = '0;
            if (push && pop) begin
                we = 1'b1;
                if (empty) begin
                    sp_next      = sp + (AW+1)'(1);
                    no_path_next = 1'b1;
                end else begin
                    waddr  = AW'(sp - (AW+1)'(1));
                    rd_pop = 1'b1;
                end
            end else if (push) begin
                if (full) begin
                    ovf_next = 1'b1;
                end else begin
                    we      = 1'b1;
                    sp_next = sp + (AW+1)'(1);
                end
            end else if (pop) begin
                if (empty) begin
                    no_path_next = 1'b1;
                end else begin
                    rd_pop  = 1'b1;
                    sp_next = sp - (AW+1)'(1);
                end
            end
        end else if (qpop) begin
            if (rp < sp) begin
                rd_rep  = 1'b1;
                mv_next = 1'b1;
                rp_next = rp + (AW+1)'(1);
            end else begin
                err_next = 1'b1;
            end
        end

        if (clr) begin
            sp_next      = '0;
            rp_next      = '0;
            mv_next      = 1'b0;
            err_next     = 1'b0;
            no_path_next = 1'b0;
            ovf_next     = 1'b0;
            we           = 1'b0;
            rd_pop       = 1'b0;
            rd_rep       = 1'b0;
        end
    end

    path_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .we       (we),
        .waddr    (waddr),
        .wdata    (din),
        .raddr    (raddr),
        .rd_pop   (rd_pop),
        .rd_rep   (rd_rep),
        .pop_data (poped),
        .rep_data (move_out)
    );

`ifdef MOVE_STACK_STATS_EN
    // High-water mark tracks the next depth so it is current with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_depth <= '0;
            replayed  <= '0;
        end else if (clr) begin
            max_depth <= '0;
            replayed  <= '0;
        end else begin
            if (sp_next > max_depth) max_depth <= sp_next;
            if (!show)        replayed <= '0;
            else if (mv_next) replayed <= replayed + (AW+1)'(1);
        end
    end
`endif

endmodule

// File: tb/tb_move_stack.sv
// Scoreboard bench for move_stack: replay moves are queued as expected and checked
// by a monitor on move_valid; stack state is checked directly after each step.
module tb_move_stack;
    import move_stack_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst, clr, push, pop, show, qpop;
    logic [DIR_W-1:0] din;
    logic [DIR_W-1:0] poped, move_out;
    logic             move_valid, err, empty, full, no_path, ovf;
    logic [AW:0]      count;
`ifdef MOVE_STACK_STATS_EN
    logic [AW:0]      max_depth, replayed;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    dir_t exp_moves[$];

    always #5 clk = ~clk;

    move_stack #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .push       (push),
        .pop        (pop),
        .din        (din),
        .poped      (poped),
        .show       (show),
        .qpop       (qpop),
        .move_out   (move_out),
        .move_valid (move_valid),
        .err        (err),
        .empty      (empty),
        .full       (full),
        .no_path    (no_path),
        .ovf        (ovf),
`ifdef MOVE_STACK_STATS_EN
        .max_depth  (max_depth),
        .replayed   (replayed),
`endif
        .count      (count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Replay monitor: every move_valid strobe must match the oldest queued move.
    always @(negedge clk) begin
        if (!rst && move_valid) begin
            n_cmp++;
            if (exp_moves.size() == 0) begin
                n_fail++;
                $display("FAIL replay_unexpected: got move %0d expected no move", move_out);
            end else begin
                dir_t e;
                e = exp_moves.pop_front();
                if (move_out !== e) begin
                    n_fail++;
                    $display("FAIL replay_move: got %0d expected %0d", move_out, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; qpop = 1'b0; clr = 1'b0;
    endtask

    task automatic do_clr();
        idle(); clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic do_push(input dir_t d);
        idle(); push = 1'b1; din = d; step(); push = 1'b0;
    endtask

    task automatic do_pop();
        idle(); pop = 1'b1; step(); pop = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_count"},      int'(count), 0);
        chk({tag, "_empty"},      int'(empty), 1);
        chk({tag, "_full"},       int'(full), 0);
        chk({tag, "_poped"},      int'(poped), 0);
        chk({tag, "_move_out"},   int'(move_out), 0);
        chk({tag, "_move_valid"}, int'(move_valid), 0);
        chk({tag, "_err"},        int'(err), 0);
        chk({tag, "_no_path"},    int'(no_path), 0);
        chk({tag, "_ovf"},        int'(ovf), 0);
    endtask

    initial begin
        rst = 1'b1; show = 1'b0; din = UP;
        idle();
        step(); step();
        rst = 1'b0;
        step();
        check_reset_state("reset");

        // Basic push/pop.
        do_push(UP); do_push(RIGHT); do_push(RIGHT); do_push(DOWN);
        chk("push4_count", int'(count), 4);
        do_pop();
        chk("pop1_poped", int'(poped), int'(DOWN));
        chk("pop1_count", int'(count), 3);
        do_pop();
        chk("pop2_poped", int'(poped), int'(RIGHT));
        chk("pop2_count", int'(count), 2);
        step();
        chk("poped_hold", int'(poped), int'(RIGHT));

        // Replay with exhaustion; push ignored in replay mode.
        do_clr();
        chk("clr_count", int'(count), 0);
        chk("clr_poped", int'(poped), 0);
        do_push(UP); do_push(LEFT);
        show = 1'b1;
        push = 1'b1; din = DOWN; step(); push = 1'b0;
        chk("show_push_ignored", int'(count), 2);
        exp_moves.push_back(UP);
        exp_moves.push_back(LEFT);
        qpop = 1'b1;
        step(); step();
        chk("replay_err_low", int'(err), 0);
        step();
        chk("replay_err_set", int'(err), 1);
        chk("replay_mv_low", int'(move_valid), 0);
        step();
        chk("replay_err_hold", int'(err), 1);
        qpop = 1'b0;
        step();
        chk("replay_err_clear", int'(err), 0);
        show = 1'b0; step();
        show = 1'b1;
        exp_moves.push_back(UP);
        qpop = 1'b1; step(); qpop = 1'b0;
        step();
        show = 1'b0; step();
        chk("replay_count_frozen", int'(count), 2);

        // Pop while empty, then overflow.
        do_clr();
        do_push(DOWN); do_pop();
        chk("pre_empty_poped", int'(poped), int'(DOWN));
        do_pop();
        chk("empty_pop_no_path", int'(no_path), 1);
        chk("empty_pop_poped", int'(poped), int'(DOWN));
        chk("empty_pop_count", int'(count), 0);
        do_clr();
        for (int i = 0; i < int'(DEPTH); i++) do_push(dir_t'(i));
        chk("fill_full", int'(full), 1);
        chk("fill_ovf", int'(ovf), 0);
        do_push(UP);
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_count", int'(count), int'(DEPTH));
        do_pop();
        chk("full_pop_poped", int'(poped), int'(DOWN));
        chk("full_pop_count", int'(count), int'(DEPTH) - 1);
        chk("full_pop_full", int'(full), 0);

        // Replace (push+pop together).
        do_clr();
        do_push(UP); do_push(RIGHT); do_push(DOWN);
        idle(); push = 1'b1; pop = 1'b1; din = LEFT; step(); idle();
        chk("replace_count", int'(count), 3);
        chk("replace_poped", int'(poped), int'(DOWN));
        chk("replace_no_path", int'(no_path), 0);
        show = 1'b1;
        exp_moves.push_back(UP);
        exp_moves.push_back(RIGHT);
        exp_moves.push_back(LEFT);
        qpop = 1'b1; step(); step(); step(); qpop = 1'b0;
        step();
        show = 1'b0; step();
        do_clr();
        idle(); push = 1'b1; pop = 1'b1; din = RIGHT; step(); idle();
        chk("replace_empty_count", int'(count), 1);
        chk("replace_empty_no_path", int'(no_path), 1);

`ifdef MOVE_STACK_STATS_EN
        do_clr();
        for (int i = 0; i < 5; i++) do_push(dir_t'(i));
        do_pop(); do_pop(); do_pop();
        chk("stats_max_depth", int'(max_depth), 5);
        chk("stats_count", int'(count), 2);
        show = 1'b1;
        exp_moves.push_back(UP);
        exp_moves.push_back(RIGHT);
        qpop = 1'b1; step(); step(); qpop = 1'b0;
        step();
        chk("stats_replayed", int'(replayed), 2);
        show = 1'b0; step();
`endif

        // Asynchronous reset mid-replay.
        do_clr();
        do_push(RIGHT); do_push(LEFT);
        show = 1'b1;
        exp_moves.push_back(RIGHT);
        qpop = 1'b1; step();
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        idle(); show = 1'b0;
        step();
        rst = 1'b0;
        step();

        chk("scoreboard_drained", exp_moves.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
